bios_loader: RTL and testbench

UART-fed boot monitor for the RV32I SoC. It sits between the byte-stream UART and the RAM write/read ports and holds the core in reset while the host loads a program. Compared with the single-byte bios, it adds:
- full-width address load
- counted bursts with auto-increment
- real read-back over the output stream
- ACK/error responses
- a timed CPU reset pulse
- width/latency parameters

Once BOOT executes, the block goes silent and releases the CPU.

---
 rtl/bios_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_bios_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_loader.sv
// bios_loader: UART-fed boot monitor for the RV32I SoC.
//
// Sits between a byte-stream host link and the RAM read/write ports. The host
// sends opcodes (NOP, BOOT, RST, SETADDR, WRITE, READ) plus little-endian
// operands. The block answers every command with one response byte (0xA5 ACK,
// 0xEE for an unknown opcode). Once BOOT has been acknowledged it goes silent
// and reports o_booted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clk_en            FSM advances only when high; everything holds when low
//   o_rst             CPU reset pulse (RST_CYCLES enabled cycles long)
//   o_booted          sticky "BOOT executed" flag
//   o_read_req        one-cycle RAM read strobe, o_read_addr = current addr
//   i_read_data       RAM data, valid READ_LATENCY cycles after o_read_req
//   o_write_enable    one-cycle RAM write strobe with o_byte_enable all ones
//   o_write_addr/data current addr and the assembled write word
//   i_data/i_valid    host byte in,  o_in_ready accepts it
//   o_data/o_valid    response byte out, i_out_ready accepts it
//
// Handshakes: a byte moves on any cycle where valid, ready and clk_en are all
// high. o_data/o_valid are registered; once o_valid is up, o_data is held until
// it is taken, and the next byte may follow on the very next cycle.
module bios_loader #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   parameter int RST_CYCLES   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_en,
   output logic                    o_rst,
   output logic                    o_booted,
   output logic                    o_read_req,
   output logic [ADDR_WIDTH-1:0]   o_read_addr,
   input  logic [DATA_WIDTH-1:0]   i_read_data,
   output logic                    o_write_enable,
   output logic [DATA_WIDTH/8-1:0] o_byte_enable,
   output logic [ADDR_WIDTH-1:0]   o_write_addr,
   output logic [DATA_WIDTH-1:0]   o_write_data,
   input  logic [7:0]              i_data,
   input  logic                    i_valid,
   output logic                    o_in_ready,
   output logic [7:0]              o_data,
   output logic                    o_valid,
   input  logic                    i_out_ready
);

   localparam int DATA_BYTES = DATA_WIDTH / 8;
   localparam int ADDR_BYTES = ADDR_WIDTH / 8;
   localparam int RCW        = $clog2(RST_CYCLES + 1);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ADDR     = 4'd1;
   localparam logic [3:0] S_COUNT    = 4'd2;
   localparam logic [3:0] S_WDATA    = 4'd3;
   localparam logic [3:0] S_WSTROBE  = 4'd4;
   localparam logic [3:0] S_RREQ     = 4'd5;
   localparam logic [3:0] S_RWAIT    = 4'd6;
   localparam logic [3:0] S_RSEND    = 4'd7;
   localparam logic [3:0] S_RSTPULSE = 4'd8;
   localparam logic [3:0] S_ACK      = 4'd9;
   localparam logic [3:0] S_ERR      = 4'd10;
   localparam logic [3:0] S_BOOTED   = 4'd11;

   localparam logic [7:0] ACK_BYTE = 8'hA5;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

   logic [3:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [8:0]            count_q, count_d;     // words left; 256 fits
   logic [7:0]            idx_q, idx_d;         // byte index inside a field/word
   logic [DATA_WIDTH-1:0] word_q, word_d;       // write assembly / read shift-out
   logic [2:0]            lat_q, lat_d;
   logic [RCW-1:0]        rcnt_q, rcnt_d;
   logic                  rst_q, rst_d;
   logic                  booted_q, booted_d;
   logic                  valid_q, valid_d;
   logic [7:0]            data_q, data_d;
   logic                  is_read_q, is_read_d;
   logic                  boot_pend_q, boot_pend_d; // ACK being sent belongs to BOOT

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      idx_d       = idx_q;
      word_d      = word_q;
      lat_d       = lat_q;
      rcnt_d      = rcnt_q;
      rst_d       = rst_q;
      booted_d    = booted_q;
      valid_d     = valid_q;
      data_d      = data_q;
      is_read_d   = is_read_q;
      boot_pend_d = boot_pend_q;
      if (clk_en) begin
         case (state_q)
            S_IDLE: if (i_valid) begin
               case (i_data)
                  8'h00: begin state_d = S_ACK; valid_d = 1'b1; data_d = ACK_BYTE; end
                  8'h01: begin
                     state_d = S_ACK; valid_d = 1'b1; data_d = ACK_BYTE; boot_pend_d = 1'b1;
                  end
                  8'h02: begin state_d = S_RSTPULSE; rst_d = 1'b1; rcnt_d = '0; end
                  8'h03: begin state_d = S_ADDR; idx_d = '0; end
                  8'h04: begin state_d = S_COUNT; is_read_d = 1'b0; end
                  8'h05: begin state_d = S_COUNT; is_read_d = 1'b1; end
                  default: begin state_d = S_ERR; valid_d = 1'b1; data_d = ERR_BYTE; end
               endcase
            end
            S_ADDR: if (i_valid) begin
               // Little-endian: each new byte enters at the top and slides down.
               addr_d = ADDR_WIDTH'({i_data, addr_q} >> 8);
               if (idx_q == 8'(ADDR_BYTES - 1)) begin
                  state_d = S_ACK; valid_d = 1'b1; data_d = ACK_BYTE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
            S_COUNT: if (i_valid) begin
               count_d = (i_data == 8'd0) ? 9'd256 : {1'b0, i_data};
               idx_d   = '0;
               state_d = is_read_q ? S_RREQ : S_WDATA;
            end
            S_WDATA: if (i_valid) begin
               word_d = DATA_WIDTH'({i_data, word_q} >> 8);
               if (idx_q == 8'(DATA_BYTES - 1)) state_d = S_WSTROBE;
               else                              idx_d   = idx_q + 8'd1;
            end
            S_WSTROBE: begin
               addr_d  = addr_q + ADDR_WIDTH'(DATA_BYTES);
               count_d = count_q - 9'd1;
               idx_d   = '0;
               if (count_q == 9'd1) begin
                  state_d = S_ACK; valid_d = 1'b1; data_d = ACK_BYTE;
               end else begin
                  state_d = S_WDATA;
               end
            end
            S_RREQ: begin
               state_d = S_RWAIT;
               lat_d   = '0;
            end
            S_RWAIT: begin
               if (lat_q == 3'(READ_LATENCY - 1)) begin
                  word_d  = i_read_data;
                  data_d  = i_read_data[7:0];
                  valid_d = 1'b1;
                  idx_d   = '0;
                  state_d = S_RSEND;
               end else begin
                  lat_d = lat_q + 3'd1;
               end
            end
            S_RSEND: if (valid_q && i_out_ready) begin
               if (idx_q == 8'(DATA_BYTES - 1)) begin
                  addr_d  = addr_q + ADDR_WIDTH'(DATA_BYTES);
                  count_d = count_q - 9'd1;
                  if (count_q == 9'd1) begin
                     state_d = S_ACK; data_d = ACK_BYTE;   // o_valid stays up
                  end else begin
                     state_d = S_RREQ; valid_d = 1'b0;
                  end
               end else begin
                  word_d = word_q >> 8;
                  data_d = word_d[7:0];
                  idx_d  = idx_q + 8'd1;
               end
            end
            S_RSTPULSE: begin
               if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                  rst_d = 1'b0; state_d = S_ACK; valid_d = 1'b1; data_d = ACK_BYTE;
               end else begin
                  rcnt_d = rcnt_q + RCW'(1);
               end
            end
            S_ACK, S_ERR: if (valid_q && i_out_ready) begin
               valid_d     = 1'b0;
               state_d     = boot_pend_q ? S_BOOTED : S_IDLE;
               booted_d    = boot_pend_q;
               boot_pend_d = 1'b0;
            end
            S_BOOTED: begin
               state_d = S_BOOTED;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         lat_q       <= '0;
         rcnt_q      <= '0;
         rst_q       <= 1'b0;
         booted_q    <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         is_read_q   <= 1'b0;
         boot_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         lat_q       <= lat_d;
         rcnt_q      <= rcnt_d;
         rst_q       <= rst_d;
         booted_q    <= booted_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         is_read_q   <= is_read_d;
         boot_pend_q <= boot_pend_d;
      end
   end

   // Strobes are qualified by clk_en so a frozen FSM never repeats a RAM access.
   assign o_write_enable = (state_q == S_WSTROBE) && clk_en;
   assign o_read_req     = (state_q == S_RREQ) && clk_en;
   assign o_byte_enable  = {DATA_BYTES{o_write_enable}};
   assign o_write_addr   = addr_q;
   assign o_read_addr    = addr_q;
   assign o_write_data   = word_q;
   assign o_in_ready     = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                           (state_q == S_COUNT) || (state_q == S_WDATA);
   assign o_data         = data_q;
   assign o_valid        = valid_q;
   assign o_rst          = rst_q;
   assign o_booted       = booted_q;

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: directed plus randomized checks of bios_loader against a
// command-level reference model (expected bytes, writes and reads queued per
// command from a flat memory array and a running address).
`timescale 1ns/1ps
module tb_bios_loader;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DB = 4;
   localparam int RL = 2;
   localparam int RC = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_en = 1'b1;
   always #5 clk = ~clk;

   logic          o_rst, o_booted, o_read_req, o_write_enable, o_in_ready, o_valid;
   logic [AW-1:0] o_read_addr, o_write_addr;
   logic [DW-1:0] i_read_data, o_write_data;
   logic [DB-1:0] o_byte_enable;
   logic [7:0]    i_data = 8'h00;
   logic [7:0]    o_data;
   logic          i_valid = 1'b0;
   logic          i_out_ready = 1'b0;

   bios_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .RST_CYCLES(RC)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .o_rst(o_rst), .o_booted(o_booted),
      .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
      .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
      .o_write_addr(o_write_addr), .o_write_data(o_write_data),
      .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready),
      .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready)
   );

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [7:0]  exp_q[$];
   logic [63:0] exp_wr_q[$];     // {addr, data}
   logic [31:0] exp_rd_q[$];
   logic [31:0] ref_mem[256];    // model memory, word index = addr[9:2]
   logic [31:0] ram[256];        // RAM seen by the DUT
   logic [31:0] wbuf[256];
   logic [31:0] m_addr;
   int  out_cnt = 0;
   int  rst_hi = 0;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitors and RAM model ----------------
   logic        ram_init = 1'b0;
   logic        pend = 1'b0;
   logic [7:0]  pend_data = 8'h00;
   logic        req_n = 1'b0;
   logic [31:0] raddr_n = '0;
   logic [1:0]  vp = 2'b00;
   logic [31:0] ap0 = '0, ap1 = '0;
   logic [8:0]  ob;
   logic [64:0] we;
   logic [32:0] re;

   always @(negedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] = ref_mem[i];
         ram_init = 1'b1;
      end
      req_n   = rst_n && o_read_req;
      raddr_n = o_read_addr;
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check("stall_valid", 65'(o_valid), 65'(1));
            check("stall_data", 65'(o_data), 65'(pend_data));
         end
         if (o_valid && i_out_ready && clk_en) begin
            out_cnt++;
            if (exp_q.size() != 0) ob = {1'b0, exp_q.pop_front()};
            else                   ob = 9'h100;
            check("out_byte", 65'({1'b0, o_data}), 65'(ob));
         end
         pend      = o_valid && !(i_out_ready && clk_en);
         pend_data = o_data;
         if (o_write_enable) begin
            if (exp_wr_q.size() != 0) we = {1'b0, exp_wr_q.pop_front()};
            else                      we = {1'b1, 64'h0};
            check("wr_addr_data", {1'b0, o_write_addr, o_write_data}, we);
            check("wr_byte_en", 65'(o_byte_enable), 65'(4'hF));
            ram[o_write_addr[9:2]] = o_write_data;
         end
         if (o_read_req) begin
            if (exp_rd_q.size() != 0) re = {1'b0, exp_rd_q.pop_front()};
            else                      re = {1'b1, 32'h0};
            check("rd_addr", 65'({1'b0, o_read_addr}), 65'(re));
         end
         if (o_rst && clk_en) rst_hi++;
      end
   end

   always @(posedge clk) begin
      vp  <= {vp[0], req_n};
      ap0 <= raddr_n;
      ap1 <= ap0;
   end
   assign i_read_data = vp[1] ? ram[ap1[9:2]] : '0;

   initial begin
      forever begin
         @(posedge clk);
         #1 i_out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic done;
      done    = 1'b0;
      i_data  = b;
      i_valid = 1'b1;
      for (int k = 0; k < 4000 && !done; k++) begin
         @(negedge clk);
         done = o_in_ready && clk_en;
         step();
      end
      i_valid = 1'b0;
      check("send_accept", 65'(done), 65'(1));
      repeat ($urandom_range(0, 1)) step();
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 20000 &&
           (exp_q.size() != 0 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0); k++) step();
      check("drain_out", 65'(exp_q.size()), 65'(0));
      check("drain_wr", 65'(exp_wr_q.size()), 65'(0));
      check("drain_rd", 65'(exp_rd_q.size()), 65'(0));
      step();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      i_valid = 1'b0;
      clk_en  = 1'b1;
      repeat (3) step();
      check("rst_in_ready", 65'(o_in_ready), 65'(1));
      check("rst_valid", 65'(o_valid), 65'(0));
      check("rst_data", 65'(o_data), 65'(0));
      check("rst_o_rst", 65'(o_rst), 65'(0));
      check("rst_booted", 65'(o_booted), 65'(0));
      check("rst_strobes", 65'({o_read_req, o_write_enable, o_byte_enable}), 65'(0));
      check("rst_addr", 65'({o_read_addr, o_write_addr}), 65'(0));
      exp_q.delete();
      exp_wr_q.delete();
      exp_rd_q.delete();
      m_addr = '0;
      rst_n  = 1'b1;
      step();
   endtask

   // ---------------- command-level reference model ----------------
   task automatic cmd_nop();
      exp_q.push_back(8'hA5);
      send_byte(8'h00);
   endtask

   task automatic cmd_bad(input logic [7:0] op);
      exp_q.push_back(8'hEE);
      send_byte(op);
   endtask

   task automatic cmd_setaddr(input logic [31:0] a);
      exp_q.push_back(8'hA5);
      m_addr = a;
      send_byte(8'h03);
      send_word(a);
   endtask

   task automatic cmd_write(input int n);
      int cnt;
      cnt = (n == 0) ? 256 : n;
      for (int i = 0; i < cnt; i++) begin
         exp_wr_q.push_back({m_addr, wbuf[i]});
         ref_mem[m_addr[9:2]] = wbuf[i];
         m_addr = m_addr + 32'd4;
      end
      exp_q.push_back(8'hA5);
      send_byte(8'h04);
      send_byte(8'(n));
      for (int i = 0; i < cnt; i++) send_word(wbuf[i]);
   endtask

   task automatic model_read(input int n);
      int cnt;
      logic [31:0] w;
      cnt = (n == 0) ? 256 : n;
      for (int i = 0; i < cnt; i++) begin
         w = ref_mem[m_addr[9:2]];
         exp_rd_q.push_back(m_addr);
         for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
         m_addr = m_addr + 32'd4;
      end
      exp_q.push_back(8'hA5);
   endtask

   task automatic cmd_read(input int n);
      model_read(n);
      send_byte(8'h05);
      send_byte(8'(n));
   endtask

   // ---------------- directed + random sequence ----------------
   int base;
   int n;
   logic [31:0] a;
   logic [7:0]  op;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      m_addr = '0;
      step();
      do_reset();

      // NOP: single ACK, no RAM traffic
      base = out_cnt;
      cmd_nop();
      wait_drain();
      check("nop_bytes", 65'(out_cnt - base), 65'(1));

      // Write two words at 0x10
      wbuf[0] = 32'h44332211;
      wbuf[1] = 32'h88776655;
      cmd_setaddr(32'h0000_0010);
      cmd_write(2);
      wait_drain();

      // Read them back (bytes 11..88 then A5)
      cmd_setaddr(32'h0000_0010);
      cmd_read(2);
      wait_drain();
      check("read_addr_adv", 65'(o_read_addr), 65'(32'h18));

      // Unknown opcode
      cmd_bad(8'h7F);
      wait_drain();
      check("err_idle_ready", 65'(o_in_ready), 65'(1));

      // Address wrap past the top
      wbuf[0] = $urandom;
      wbuf[1] = $urandom;
      cmd_setaddr(32'hFFFF_FFFC);
      cmd_write(2);
      wait_drain();
      cmd_setaddr(32'hFFFF_FFFC);
      cmd_read(2);
      wait_drain();

      // Randomized bursts and opcodes
      for (int r = 0; r < 8; r++) begin
         a = 32'($urandom_range(8, 150)) << 2;
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) wbuf[i] = $urandom;
         cmd_setaddr(a);
         cmd_write(n);
         wait_drain();
         cmd_setaddr(a);
         cmd_read(n);
         wait_drain();
         op = 8'($urandom_range(6, 255));
         cmd_bad(op);
         cmd_nop();
         wait_drain();
      end

      // Count byte 0 means 256 words
      for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
      cmd_setaddr(32'h0000_0400);
      cmd_write(0);
      wait_drain();
      check("n0_addr", 65'(o_write_addr), 65'(32'h800));
      cmd_setaddr(32'h0000_0400);
      cmd_read(0);
      wait_drain();

      // RST pulse, with a clk_en freeze in the middle
      base = rst_hi;
      exp_q.push_back(8'hA5);
      send_byte(8'h02);
      check("rst_pulse_on", 65'(o_rst), 65'(1));
      clk_en = 1'b0;
      repeat (3) step();
      check("rst_pulse_frozen", 65'(o_rst), 65'(1));
      clk_en = 1'b1;
      wait_drain();
      check("rst_pulse_len", 65'(rst_hi - base), 65'(RC));
      check("rst_pulse_off", 65'(o_rst), 65'(0));

      // Reset in the middle of a READ burst after three bytes
      cmd_setaddr(32'h0000_0010);
      wait_drain();
      base = out_cnt;
      cmd_read(2);
      for (int k = 0; k < 4000 && out_cnt < base + 3; k++) @(posedge clk);
      check("mid_rd_count", 65'(out_cnt - base), 65'(3));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rd_valid", 65'(o_valid), 65'(0));
      check("mid_rd_req", 65'(o_read_req), 65'(0));
      do_reset();
      base = out_cnt;
      cmd_nop();
      wait_drain();
      check("post_rst_nop", 65'(out_cnt - base), 65'(1));

      // BOOT, then silence
      exp_q.push_back(8'hA5);
      send_byte(8'h01);
      wait_drain();
      step();
      check("boot_flag", 65'(o_booted), 65'(1));
      check("boot_in_ready", 65'(o_in_ready), 65'(0));
      base    = out_cnt;
      i_data  = 8'h00;
      i_valid = 1'b1;
      repeat (20) step();
      i_valid = 1'b0;
      check("boot_silent_valid", 65'(o_valid), 65'(0));
      check("boot_silent_bytes", 65'(out_cnt - base), 65'(0));
      check("boot_flag_hold", 65'(o_booted), 65'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
